command_decoder: RTL and testbench
==================================

Name: command_decoder

Overview:
- Assembles the SUMP-style command stream arriving byte-by-byte from the UART receiver into one opcode and one 32-bit argument.
- Presents each completed command to the controller with a single-cycle cmd_recv_rx strobe.
- Short commands (opcode bit 7 = 0) are 1 byte. Long commands (opcode bit 7 = 1) are the opcode followed by 4 argument bytes, least-significant first.

Parameters:
- TIMEOUT_CYCLES, 100000, inter-byte timeout in clock cycles (used only with CMD_TIMEOUT_EN); must be ≥ 2.

Ports:
- clock  in  1  system clock; all logic on the rising edge
- ext_reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte; valid only while rx_valid is high
- rx_valid  in  1  single-cycle strobe per received byte; at most one byte per cycle
- opcode  out  8  opcode of the last completed command
- command  out  32  argument of the last completed command; 0 for short commands
- cmd_recv_rx  out  1  one-cycle pulse: opcode/command hold a new command
- busy  out  1  high while a long command is partially received
- cmd_timeout  out  1  one-cycle pulse: partial long command discarded

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - opcode = 0x00, command = 0x00000000
  - cmd_recv_rx = 0, busy = 0, cmd_timeout = 0
  - state = IDLE, internal byte counter = 0, assembly registers = 0
- Internal storage:
  - op_asm[7:0]: opcode being assembled
  - arg_asm[31:0]: argument being assembled
  - cnt[1:0]: argument-byte index
- State IDLE (busy = 0):
  - rx_valid with rx_data[7] = 0 (short command):
    - next edge: opcode <= rx_data, command <= 0, cmd_recv_rx = 1 for that cycle
    - stay in IDLE
  - rx_valid with rx_data[7] = 1 (long command):
    - op_asm <= rx_data, arg_asm <= 0, cnt <= 0
    - go to ARGS
- State ARGS (busy = 1):
  - rx_valid: arg_asm[8*cnt+7 : 8*cnt] <= rx_data, cnt <= cnt + 1
  - rx_valid with cnt = 3:
    - next edge: opcode <= op_asm, command <= {rx_data, arg_asm[23:0]}
    - cmd_recv_rx = 1 for that cycle; go to IDLE
  - Bit 7 of argument bytes is not inspected; any value is data.
- Latency: cmd_recv_rx is high exactly one cycle, in the cycle after the edge that sampled the final byte's rx_valid.
- Output hold:
  - opcode/command change only on the edge that raises cmd_recv_rx.
  - They hold their value across later partial receptions, so the controller may sample them for any number of cycles after the strobe.
- Back-to-back bytes on consecutive cycles are accepted without loss.
  - A new short opcode arriving the cycle cmd_recv_rx is high is decoded normally; cmd_recv_rx is then high on the next cycle as well.
- Resynchronisation:
  - The host's five 0x00 reset bytes, received while in IDLE, produce five separate 0x00 commands.
  - Received while in ARGS, the 0x00 bytes complete the pending long command, then decode as 0x00 commands.
- busy deasserts in the same cycle cmd_recv_rx or cmd_timeout asserts.
- Only ext_reset affects this block; the controller's reset output is not connected here.

Optional Feature:
- Macro: CMD_TIMEOUT_EN
- Defined:
  - A counter, sized $clog2(TIMEOUT_CYCLES+1), clears on every rx_valid and increments each cycle while in ARGS.
  - When it reaches TIMEOUT_CYCLES with no rx_valid that cycle:
    - op_asm/arg_asm/cnt are discarded and the state returns to IDLE
    - cmd_timeout pulses for one cycle on the following cycle; opcode/command are unchanged, cmd_recv_rx is not asserted
  - rx_valid in the same cycle as the terminal count wins: the byte is accepted and no timeout occurs.
  - The counter is held at 0 in IDLE.
- Not defined:
  - No counter; ARGS waits indefinitely.
  - cmd_timeout is tied to 0.

Test Plan:
- Short command: single byte 0x02 → one cycle later cmd_recv_rx = 1 for exactly 1 cycle, opcode = 0x02, command = 0x00000000, busy never high.
- Long command: bytes 0x80, 0x11, 0x22, 0x33, 0x44, each 10 cycles apart → busy high from after 0x80 until the strobe; single strobe with opcode = 0x80, command = 0x44332211; outputs stable for 50 cycles afterwards.
- Back-to-back traffic: 0xC0, 0xFF, 0x00, 0x00, 0x00, then 0x01 on six consecutive cycles → two strobes, first opcode = 0xC0 / command = 0x000000FF, second opcode = 0x01 / command = 0.
- Reset mid-command: ext_reset asserted after 0x81, 0xAA → outputs immediately 0, state IDLE; then 0x04 → opcode = 0x04, command = 0.
- Timeout (CMD_TIMEOUT_EN, TIMEOUT_CYCLES = 20): 0x80, 0x55, then silence → cmd_timeout pulses once with no cmd_recv_rx and opcode/command unchanged; a following 0x02 decodes correctly. Without the macro, the same stimulus leaves busy = 1 indefinitely.
- Timeout boundary (CMD_TIMEOUT_EN, TIMEOUT_CYCLES = 20): next byte arrives exactly on the terminal-count cycle → no timeout; the command completes normally.

Source files
------------

// File: rtl/command_decoder_if.sv
// command_decoder_if: byte stream in, decoded command out, for the SUMP command decoder
// Signals:
//   rx_data[7:0]   received byte, valid while rx_valid is high
//   rx_valid       single-cycle strobe per received byte
//   opcode[7:0]    opcode of the last completed command
//   command[31:0]  argument of the last completed command (0 for short commands)
//   cmd_recv_rx    one-cycle pulse: opcode/command hold a new command
//   busy           high while a long command is partially received
//   cmd_timeout    one-cycle pulse: partial long command discarded
// Modports: master = byte source / command consumer, slave = decoder.
interface command_decoder_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  opcode;
    logic [31:0] command;
    logic        cmd_recv_rx;
    logic        busy;
    logic        cmd_timeout;
    modport master (
        output rx_data, rx_valid,
        input  opcode, command, cmd_recv_rx, busy, cmd_timeout
    );
    modport slave (
        input  rx_data, rx_valid,
        output opcode, command, cmd_recv_rx, busy, cmd_timeout
    );
endinterface

// File: rtl/command_decoder.sv
// command_decoder: assembles SUMP command bytes into an opcode and 32-bit argument
// Ports:
//   clock      system clock, rising edge
//   ext_reset  asynchronous active-high reset
//   bus        command_decoder_if.slave (rx_data/rx_valid in; opcode, command,
//              cmd_recv_rx, busy, cmd_timeout out)
// Parameter TIMEOUT_CYCLES: inter-byte timeout in cycles (>= 2), used only when
// the macro CMD_TIMEOUT_EN is defined; otherwise cmd_timeout is tied low and a
// partial long command waits indefinitely.
module command_decoder #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic               clock,
    input logic               ext_reset,
    command_decoder_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ARGS = 1'b1;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    logic [0:0]  state;
    logic [7:0]  op_asm;
    logic [31:0] arg_asm;
    logic [1:0]  cnt;
    logic [7:0]  opcode;
    logic [31:0] command;
    logic        cmd_recv_rx;
    logic        timed_out;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0] tcnt;
    logic          cmd_timeout;

    // Any received byte restarts the idle count; IDLE holds it at zero.
    always_ff @(posedge clock or posedge ext_reset)
        if (ext_reset)
            tcnt <= '0;
        else
            tcnt <= (state == IDLE || bus.rx_valid || tcnt == TLIM) ? '0 : tcnt + TW'(1);

    // A byte in the terminal-count cycle wins over the timeout.
    assign timed_out = (state == ARGS) && !bus.rx_valid && (tcnt == TLIM);

    always_ff @(posedge clock or posedge ext_reset)
        if (ext_reset)
            cmd_timeout <= 1'b0;
        else
            cmd_timeout <= timed_out;

    assign bus.cmd_timeout = cmd_timeout;
`else
    assign timed_out       = 1'b0;
    assign bus.cmd_timeout = 1'b0;
`endif

    always_ff @(posedge clock or posedge ext_reset)
        if (ext_reset) begin
            state       <= IDLE;
            op_asm      <= '0;
            arg_asm     <= '0;
            cnt         <= '0;
            opcode      <= '0;
            command     <= '0;
            cmd_recv_rx <= 1'b0;
        end else begin
            cmd_recv_rx <= 1'b0;
            if (state == IDLE) begin
                if (bus.rx_valid && !bus.rx_data[7]) begin
                    opcode      <= bus.rx_data;
                    command     <= '0;
                    cmd_recv_rx <= 1'b1;
                end else if (bus.rx_valid) begin
                    op_asm  <= bus.rx_data;
                    arg_asm <= '0;
                    cnt     <= '0;
                    state   <= ARGS;
                end
            end else if (bus.rx_valid) begin
                arg_asm[{cnt, 3'b000} +: 8] <= bus.rx_data;
                cnt                         <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    opcode      <= op_asm;
                    command     <= {bus.rx_data, arg_asm[23:0]};
                    cmd_recv_rx <= 1'b1;
                    state       <= IDLE;
                end
            end else if (timed_out) begin
                op_asm  <= '0;
                arg_asm <= '0;
                cnt     <= '0;
                state   <= IDLE;
            end
        end

    assign bus.opcode      = opcode;
    assign bus.command     = command;
    assign bus.cmd_recv_rx = cmd_recv_rx;
    assign bus.busy        = (state == ARGS);
endmodule

// File: tb/tb_command_decoder.sv
// tb_command_decoder: directed self-checking bench for command_decoder
module tb_command_decoder;
    logic clock = 1'b0;
    logic ext_reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   recv_pulses = 0;
    int   to_pulses = 0;

    command_decoder_if bus();

    command_decoder #(.TIMEOUT_CYCLES(20)) dut (
        .clock     (clock),
        .ext_reset (ext_reset),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.cmd_recv_rx === 1'b1) recv_pulses++;
        if (bus.cmd_timeout === 1'b1) to_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one byte for exactly one rising edge; returns at the negedge
    // right after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clock);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic test_reset;
        ext_reset    = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        idle(3);
        n_cmp++;
        if ({bus.opcode, bus.command, bus.cmd_recv_rx, bus.busy, bus.cmd_timeout} !== 43'd0) begin
            n_bad++;
            $display("FAIL reset_state: got op=%h cmd=%h recv=%b busy=%b to=%b, want all 0",
                     bus.opcode, bus.command, bus.cmd_recv_rx, bus.busy, bus.cmd_timeout);
        end
        ext_reset = 1'b0;
        idle(2);
    endtask

    task automatic test_short;
        int busy_seen = 0;
        @(negedge clock);
        bus.rx_data  = 8'h02;
        bus.rx_valid = 1'b1;
        if (bus.busy) busy_seen++;
        @(negedge clock);
        bus.rx_valid = 1'b0;
        if (bus.busy) busy_seen++;
        n_cmp++;
        if (bus.cmd_recv_rx !== 1'b1 || bus.opcode !== 8'h02 || bus.command !== 32'd0) begin
            n_bad++;
            $display("FAIL short_cmd: got recv=%b op=%h cmd=%h, want 1/02/00000000",
                     bus.cmd_recv_rx, bus.opcode, bus.command);
        end
        @(negedge clock);
        if (bus.busy) busy_seen++;
        n_cmp++;
        if (bus.cmd_recv_rx !== 1'b0) begin
            n_bad++;
            $display("FAIL short_pulse_width: recv=%b one cycle later, want 0", bus.cmd_recv_rx);
        end
        n_cmp++;
        if (busy_seen != 0) begin
            n_bad++;
            $display("FAIL short_busy: busy high %0d cycles, want 0", busy_seen);
        end
    endtask

    task automatic test_long;
        logic [7:0] bytes [5] = '{8'h80, 8'h11, 8'h22, 8'h33, 8'h44};
        int start = recv_pulses;
        int bad_busy = 0;
        int bad_hold = 0;
        for (int i = 0; i < 5; i++) begin
            send_byte(bytes[i]);
            if (i < 4) begin
                for (int j = 0; j < 9; j++) begin
                    if (bus.busy !== 1'b1 || bus.cmd_recv_rx !== 1'b0) bad_busy++;
                    @(negedge clock);
                end
            end
        end
        n_cmp++;
        if (bad_busy != 0) begin
            n_bad++;
            $display("FAIL long_busy: %0d cycles with busy!=1 or early strobe, want 0", bad_busy);
        end
        n_cmp++;
        if (bus.cmd_recv_rx !== 1'b1 || bus.busy !== 1'b0 || bus.opcode !== 8'h80 || bus.command !== 32'h44332211) begin
            n_bad++;
            $display("FAIL long_cmd: got recv=%b busy=%b op=%h cmd=%h, want 1/0/80/44332211",
                     bus.cmd_recv_rx, bus.busy, bus.opcode, bus.command);
        end
        for (int j = 0; j < 50; j++) begin
            @(negedge clock);
            if (bus.cmd_recv_rx !== 1'b0 || bus.opcode !== 8'h80 || bus.command !== 32'h44332211) bad_hold++;
        end
        n_cmp++;
        if (bad_hold != 0 || recv_pulses - start != 1) begin
            n_bad++;
            $display("FAIL long_hold: %0d unstable cycles, %0d strobes, want 0 and 1",
                     bad_hold, recv_pulses - start);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [6] = '{8'hC0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01};
        int bad_mid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i >= 1 && i <= 4 && (bus.busy !== 1'b1 || bus.cmd_recv_rx !== 1'b0)) bad_mid++;
            if (i == 5) begin
                n_cmp++;
                if (bus.cmd_recv_rx !== 1'b1 || bus.busy !== 1'b0 || bus.opcode !== 8'hC0 || bus.command !== 32'h000000FF) begin
                    n_bad++;
                    $display("FAIL b2b_first: got recv=%b busy=%b op=%h cmd=%h, want 1/0/C0/000000FF",
                             bus.cmd_recv_rx, bus.busy, bus.opcode, bus.command);
                end
            end
            bus.rx_data  = bytes[i];
            bus.rx_valid = 1'b1;
        end
        @(negedge clock);
        bus.rx_valid = 1'b0;
        n_cmp++;
        if (bus.cmd_recv_rx !== 1'b1 || bus.opcode !== 8'h01 || bus.command !== 32'd0) begin
            n_bad++;
            $display("FAIL b2b_second: got recv=%b op=%h cmd=%h, want 1/01/00000000",
                     bus.cmd_recv_rx, bus.opcode, bus.command);
        end
        @(negedge clock);
        n_cmp++;
        if (bus.cmd_recv_rx !== 1'b0 || bad_mid != 0) begin
            n_bad++;
            $display("FAIL b2b_gaps: recv=%b after, %0d bad mid cycles, want 0 and 0", bus.cmd_recv_rx, bad_mid);
        end
    endtask

    task automatic test_resync;
        int start = recv_pulses;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            bus.rx_data  = 8'h00;
            bus.rx_valid = 1'b1;
        end
        @(negedge clock);
        bus.rx_valid = 1'b0;
        idle(2);
        n_cmp++;
        if (recv_pulses - start != 5 || bus.opcode !== 8'h00 || bus.command !== 32'd0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL resync_zeros: got %0d strobes op=%h cmd=%h busy=%b, want 5/00/00000000/0",
                     recv_pulses - start, bus.opcode, bus.command, bus.busy);
        end
    endtask

    task automatic test_reset_mid;
        send_byte(8'h83);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h81);
        send_byte(8'hAA);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.opcode !== 8'h83 || bus.command !== 32'h04030201) begin
            n_bad++;
            $display("FAIL reset_mid_pre: got busy=%b op=%h cmd=%h, want 1/83/04030201",
                     bus.busy, bus.opcode, bus.command);
        end
        #2 ext_reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.opcode !== 8'h00 || bus.command !== 32'd0 || bus.cmd_recv_rx !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_async: got busy=%b op=%h cmd=%h recv=%b, want all 0",
                     bus.busy, bus.opcode, bus.command, bus.cmd_recv_rx);
        end
        idle(2);
        ext_reset = 1'b0;
        send_byte(8'h04);
        n_cmp++;
        if (bus.cmd_recv_rx !== 1'b1 || bus.opcode !== 8'h04 || bus.command !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_mid_after: got recv=%b op=%h cmd=%h, want 1/04/00000000",
                     bus.cmd_recv_rx, bus.opcode, bus.command);
        end
    endtask

    task automatic set_known_cmd;
        send_byte(8'h85);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        idle(2);
    endtask

    task automatic test_timeout;
        int bad = 0;
        int r0;
        int t0;
        set_known_cmd();
        r0 = recv_pulses;
        t0 = to_pulses;
        send_byte(8'h80);
        send_byte(8'h55);
`ifdef CMD_TIMEOUT_EN
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (bus.cmd_timeout !== (k == 21) || bus.busy !== (k < 21)) bad++;
        end
        n_cmp++;
        if (bad != 0 || to_pulses - t0 != 1 || recv_pulses != r0) begin
            n_bad++;
            $display("FAIL timeout_pulse: %0d bad cycles, %0d timeouts, %0d strobes, want 0/1/0",
                     bad, to_pulses - t0, recv_pulses - r0);
        end
        n_cmp++;
        if (bus.opcode !== 8'h85 || bus.command !== 32'h04030201) begin
            n_bad++;
            $display("FAIL timeout_hold: got op=%h cmd=%h, want 85/04030201", bus.opcode, bus.command);
        end
        send_byte(8'h02);
        n_cmp++;
        if (bus.cmd_recv_rx !== 1'b1 || bus.opcode !== 8'h02 || bus.command !== 32'd0) begin
            n_bad++;
            $display("FAIL timeout_recover: got recv=%b op=%h cmd=%h, want 1/02/00000000",
                     bus.cmd_recv_rx, bus.opcode, bus.command);
        end
`else
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            if (bus.busy !== 1'b1 || bus.cmd_timeout !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0 || recv_pulses != r0 || to_pulses != t0) begin
            n_bad++;
            $display("FAIL no_timeout_wait: %0d bad cycles, %0d strobes, %0d timeouts, want 0/0/0",
                     bad, recv_pulses - r0, to_pulses - t0);
        end
        n_cmp++;
        if (bus.opcode !== 8'h85 || bus.command !== 32'h04030201) begin
            n_bad++;
            $display("FAIL no_timeout_hold: got op=%h cmd=%h, want 85/04030201", bus.opcode, bus.command);
        end
        ext_reset = 1'b1;
        idle(2);
        ext_reset = 1'b0;
        idle(1);
`endif
    endtask

    task automatic test_timeout_boundary;
`ifdef CMD_TIMEOUT_EN
        int t0;
        t0 = to_pulses;
        send_byte(8'h90);
        send_byte(8'h10);
        idle(19);
        send_byte(8'h20);
        send_byte(8'h30);
        send_byte(8'h40);
        n_cmp++;
        if (bus.cmd_recv_rx !== 1'b1 || bus.opcode !== 8'h90 || bus.command !== 32'h40302010 || to_pulses != t0) begin
            n_bad++;
            $display("FAIL timeout_boundary: got recv=%b op=%h cmd=%h timeouts=%0d, want 1/90/40302010/0",
                     bus.cmd_recv_rx, bus.opcode, bus.command, to_pulses - t0);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_back_to_back();
        test_resync();
        test_reset_mid();
        test_timeout();
        test_timeout_boundary();
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
